// File: rtl/irq_sched_pkg.sv
// Shared constants, types and helpers for the CP0 interrupt scheduler.
package irq_sched_pkg;

    localparam int unsigned CFG_ADDR_W = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PRIO_W     = 32;
    localparam int unsigned PRIO_IDX_W = 5;

    // Configuration register map
    localparam logic [CFG_ADDR_W-1:0] CFG_MASK  = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] CFG_PEND  = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] CFG_CAUSE = 2'd2;
    localparam logic [CFG_ADDR_W-1:0] CFG_MODE  = 2'd3;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Configuration write request as issued by the EXE stage
    typedef struct packed {
        logic                  we;
        logic [CFG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } cfg_req_t;

    // Index of the lowest set bit; 0 when the vector is empty
    function automatic logic [PRIO_IDX_W-1:0] lowest_set_idx(input logic [PRIO_W-1:0] vec);
        logic [PRIO_IDX_W-1:0] idx;
        idx = '0;
        for (int i = PRIO_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = PRIO_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_pending_cell.sv
// One interrupt source: edge/level capture into a sticky pending bit.
module irq_pending_cell (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic w1c,
    input  logic grant_clr,
    output logic pend
);

    logic prev;
    logic set_hit;

    // A new request: rising edge in edge mode, any high sample in level mode
    always_comb begin
        set_hit = edge_mode ? (src & ~prev) : src;
    end

    // Sample history and pending bit; a same-cycle set beats both clears
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= src;
            pend <= set_hit | (pend & ~w1c & ~grant_clr);
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Fixed-priority interrupt scheduler driving the CP0 edge-sensitive IRQ input.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  cfg_we,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0]     cfg_wdata,
    output logic [DATA_W-1:0]     cfg_rdata,
    input  logic                  ir_taken,
    input  logic                  eret,
    output logic                  ir_out,
    output logic [ID_W-1:0]       active_id,
    output logic                  busy
);

    cfg_req_t          cfg;
    state_t            state;
    logic [N_SRC-1:0]  mask;
    logic [N_SRC-1:0]  mode;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  eligible;
    logic [ID_W-1:0]   winner;
    logic              take_irq;
    logic              pend_wr;

    assign cfg = '{we: cfg_we, addr: cfg_addr, wdata: cfg_wdata};

    // Write data above the source count has no register behind it
    if (N_SRC < DATA_W) begin : g_wdata_pad
        logic unused_wdata;
        assign unused_wdata = ^cfg.wdata[DATA_W-1:N_SRC];
    end

    // Arbitration: lowest eligible index wins, sampled only while IDLE
    always_comb begin
        eligible = pending & mask;
        winner   = ID_W'(lowest_set_idx(PRIO_W'(eligible)));
        take_irq = (state == IDLE) && (|eligible);
        pend_wr  = cfg.we && (cfg.addr == CFG_PEND);
    end

    // Per-source pending capture
    for (genvar i = 0; i < N_SRC; i++) begin : g_cell
        irq_pending_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .src       (irq_src[i]),
            .edge_mode (mode[i]),
            .w1c       (pend_wr && cfg.wdata[i]),
            .grant_clr (take_irq && (winner == ID_W'(i))),
            .pend      (pending[i])
        );
    end

    // MASK and MODE registers; PENDING is W1C inside the cells, CAUSE is read-only
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            mode <= '0;
        end else if (cfg.we) begin
            if (cfg.addr == CFG_MASK) begin
                mask <= cfg.wdata[N_SRC-1:0];
            end
            if (cfg.addr == CFG_MODE) begin
                mode <= cfg.wdata[N_SRC-1:0];
            end
        end
    end

    // Register read mux, zero-extended to the bus width
    always_comb begin
        cfg_rdata = '0;
        case (cfg.addr)
            CFG_MASK:  cfg_rdata = DATA_W'(mask);
            CFG_PEND:  cfg_rdata = DATA_W'(pending);
            CFG_CAUSE: begin
                cfg_rdata[DATA_W-1] = busy;
                cfg_rdata[ID_W-1:0] = active_id;
            end
            CFG_MODE:  cfg_rdata = DATA_W'(mode);
            default:   cfg_rdata = '0;
        endcase
    end

    // Service FSM: one interrupt in flight, one-cycle low gap after ERET
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ir_out    <= 1'b0;
            busy      <= 1'b0;
            active_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_irq) begin
                        state     <= ASSERT;
                        ir_out    <= 1'b1;
                        busy      <= 1'b1;
                        active_id <= winner;
                    end
                end
                ASSERT: begin
                    if (ir_taken) begin
                        state  <= SERVICE;
                        ir_out <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state <= GAP;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    ir_out <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: vector table plus hand-written corner sequences.
module tb_irq_sched;
    import irq_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        ir_taken;
    logic        eret;
    logic        ir_out;
    logic [2:0]  active_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    irq_sched #(.N_SRC(8), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ir_taken  (ir_taken),
        .eret      (eret),
        .ir_out    (ir_out),
        .active_id (active_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Rising edges of ir_out as CP0 would see them
    int   rise_cnt = 0;
    logic ir_prev  = 1'b0;
    always @(negedge clk) begin
        ir_prev <= ir_out;
        if (ir_out && !ir_prev) rise_cnt <= rise_cnt + 1;
    end

    typedef struct {
        logic        rst;
        logic [7:0]  src;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        tk;
        logic        er;
        logic        e_io;
        logic        e_bz;
        logic [2:0]  e_id;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [7:0] s, input logic we,
                                input logic [1:0] a, input logic [31:0] wd,
                                input logic tk, input logic er, input logic eio,
                                input logic ebz, input logic [2:0] eid,
                                input logic [31:0] erd);
        vec_t v;
        v.rst = r;  v.src = s;  v.we = we;  v.addr = a;  v.wd = wd;
        v.tk = tk;  v.er = er;  v.e_io = eio; v.e_bz = ebz; v.e_id = eid; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic r, input logic [7:0] s, input logic we,
                        input logic [1:0] a, input logic [31:0] wd,
                        input logic tk, input logic er);
        rst = r; irq_src = s; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        ir_taken = tk; eret = er;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic eio, input logic ebz,
                           input logic [2:0] eid);
        chk({tag, " ir_out"}, 32'(ir_out), 32'(eio));
        chk({tag, " busy"}, 32'(busy), 32'(ebz));
        chk({tag, " active_id"}, 32'(active_id), 32'(eid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = CFG_MASK;
        cfg_wdata = '0; ir_taken = 1'b0; eret = 1'b0;

        // Reset, edge source 3, sources 2+5 together, masked source 1
        vecs[0]  = mk(1, 8'h00, 0, CFG_MASK,  32'h00, 0, 0, 0, 0, 3'd0, 32'h0);
        vecs[1]  = mk(0, 8'h00, 1, CFG_MODE,  32'hFE, 0, 0, 0, 0, 3'd0, 32'hFE);
        vecs[2]  = mk(0, 8'h00, 1, CFG_MASK,  32'h08, 0, 0, 0, 0, 3'd0, 32'h08);
        vecs[3]  = mk(0, 8'h08, 0, CFG_PEND,  32'h00, 0, 0, 0, 0, 3'd0, 32'h08);
        vecs[4]  = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 0, 0, 1, 1, 3'd3, 32'h00);
        vecs[5]  = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 1, 0, 0, 1, 3'd3, 32'h80000003);
        vecs[6]  = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 1, 0, 0, 3'd3, 32'h3);
        vecs[7]  = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 0, 0, 0, 3'd3, 32'h3);
        vecs[8]  = mk(0, 8'h00, 1, CFG_MASK,  32'hFF, 0, 0, 0, 0, 3'd3, 32'hFF);
        vecs[9]  = mk(0, 8'h24, 0, CFG_PEND,  32'h00, 0, 0, 0, 0, 3'd3, 32'h24);
        vecs[10] = mk(0, 8'h24, 0, CFG_PEND,  32'h00, 0, 0, 1, 1, 3'd2, 32'h20);
        vecs[11] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 1, 0, 0, 1, 3'd2, 32'h20);
        vecs[12] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 0, 1, 0, 0, 3'd2, 32'h20);
        vecs[13] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 0, 0, 0, 0, 3'd2, 32'h20);
        vecs[14] = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 0, 1, 1, 3'd5, 32'h80000005);
        vecs[15] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 1, 0, 0, 1, 3'd5, 32'h00);
        vecs[16] = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 1, 0, 0, 3'd5, 32'h5);
        vecs[17] = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 0, 0, 0, 3'd5, 32'h5);
        vecs[18] = mk(0, 8'h00, 1, CFG_MASK,  32'h00, 0, 0, 0, 0, 3'd5, 32'h00);
        vecs[19] = mk(0, 8'h02, 0, CFG_PEND,  32'h00, 0, 0, 0, 0, 3'd5, 32'h02);
        vecs[20] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 0, 0, 0, 0, 3'd5, 32'h02);
        vecs[21] = mk(0, 8'h00, 1, CFG_MASK,  32'h02, 0, 0, 0, 0, 3'd5, 32'h02);
        vecs[22] = mk(0, 8'h00, 0, CFG_PEND,  32'h00, 0, 0, 1, 1, 3'd1, 32'h00);
        vecs[23] = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 1, 0, 0, 1, 3'd1, 32'h80000001);
        vecs[24] = mk(0, 8'h00, 0, CFG_CAUSE, 32'h00, 0, 1, 0, 0, 3'd1, 32'h1);
        vecs[25] = mk(0, 8'h00, 0, CFG_MODE,  32'h00, 0, 0, 0, 0, 3'd1, 32'hFE);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].src, vecs[i].we, vecs[i].addr, vecs[i].wd,
                 vecs[i].tk, vecs[i].er);
            chk_out($sformatf("vec[%0d]", i), vecs[i].e_io, vecs[i].e_bz, vecs[i].e_id);
            chk($sformatf("vec[%0d] rdata", i), cfg_rdata, vecs[i].e_rd);
        end

        // Level source 0 held through handler and ERET: two distinct rising edges
        base = rise_cnt;
        step(0, 8'h00, 1, CFG_MASK, 32'h01, 0, 0);  chk_out("lvl mask", 0, 0, 3'd1);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 0, 0);  chk("lvl pend set", cfg_rdata, 32'h01);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 0, 0);  chk_out("lvl assert1", 1, 1, 3'd0);
        chk("lvl pend kept", cfg_rdata, 32'h01);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 1, 0);  chk_out("lvl service1", 0, 1, 3'd0);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 0, 1);  chk_out("lvl gap", 0, 0, 3'd0);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 0, 0);  chk_out("lvl idle", 0, 0, 3'd0);
        step(0, 8'h01, 0, CFG_PEND, 32'h00, 0, 0);  chk_out("lvl assert2", 1, 1, 3'd0);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 1, 0);  chk_out("lvl service2", 0, 1, 3'd0);
        chk("lvl rising edges", 32'(rise_cnt - base), 32'd2);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 0, 1);  chk_out("lvl gap2", 0, 0, 3'd0);
        step(0, 8'h00, 1, CFG_PEND, 32'h01, 0, 0);  chk("lvl w1c", cfg_rdata, 32'h00);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 0, 0);  chk_out("lvl quiet", 0, 0, 3'd0);

        // W1C colliding with a new edge on source 4: the set wins
        step(0, 8'h00, 1, CFG_MASK, 32'h00, 0, 0);
        step(0, 8'h10, 1, CFG_PEND, 32'h10, 0, 0);  chk("w1c vs edge fresh", cfg_rdata, 32'h10);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 0, 0);  chk("w1c sticky", cfg_rdata, 32'h10);
        step(0, 8'h10, 1, CFG_PEND, 32'h10, 0, 0);  chk("w1c vs edge held", cfg_rdata, 32'h10);
        step(0, 8'h10, 1, CFG_PEND, 32'h10, 0, 0);  chk("w1c no edge", cfg_rdata, 32'h00);

        // Commitment in ASSERT, ignored strobes, read-only CAUSE
        step(0, 8'h00, 1, CFG_MASK, 32'h10, 0, 0);
        step(0, 8'h10, 0, CFG_PEND, 32'h00, 0, 0);  chk("cmt pend", cfg_rdata, 32'h10);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 0, 0);  chk_out("cmt assert", 1, 1, 3'd4);
        step(0, 8'h00, 1, CFG_MASK, 32'h00, 0, 0);  chk_out("cmt unmask", 1, 1, 3'd4);
        step(0, 8'h00, 1, CFG_PEND, 32'hFF, 0, 1);  chk_out("cmt w1c+eret", 1, 1, 3'd4);
        step(0, 8'h00, 0, CFG_PEND, 32'h00, 1, 0);  chk_out("cmt taken", 0, 1, 3'd4);
        step(0, 8'h40, 0, CFG_PEND, 32'h00, 1, 0);  chk_out("cmt taken again", 0, 1, 3'd4);
        chk("cmt pend6", cfg_rdata, 32'h40);
        step(0, 8'h40, 1, CFG_MASK, 32'hFF, 0, 0);  chk_out("cmt svc mask", 0, 1, 3'd4);
        step(0, 8'h40, 1, CFG_CAUSE, 32'hFFFFFFFF, 0, 0);
        chk("cause ro", cfg_rdata, 32'h80000004);

        // Reset in SERVICE, then a stray ERET
        step(1, 8'h40, 0, CFG_MASK, 32'h00, 0, 0);  chk_out("rst svc", 0, 0, 3'd0);
        chk("rst mask", cfg_rdata, 32'h00);
        cfg_addr = CFG_PEND; #1;
        chk("rst pend", cfg_rdata, 32'h00);
        step(0, 8'h40, 0, CFG_PEND, 32'h00, 0, 1);  chk_out("post rst eret", 0, 0, 3'd0);
        chk("rst history cleared", cfg_rdata, 32'h40);
        step(0, 8'h00, 0, CFG_MASK, 32'h00, 1, 1);  chk_out("post rst idle", 0, 0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt scheduler for the CP0 exception path. It collects N external interrupt sources and latches them as pending. It masks them, picks one by fixed priority, and drives the single edge-sensitive interrupt input of CP0. One interrupt is in service at a time. The next one is released only after the handler executes ERET.

## Interface
- N_SRC, 8, number of interrupt sources (1..32)
- ID_W, 3, width of the source index (clog2 of N_SRC, minimum 1)
- clk  in  1  main clock, rising edge
- rst  in  1  reset, synchronous, active-high
- irq_src  in  N_SRC  raw interrupt requests, synchronous to clk
- cfg_we  in  1  configuration write strobe (EXE stage)
- cfg_addr  in  2  register select: 0 MASK, 1 PENDING, 2 CAUSE, 3 MODE
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational from cfg_addr, zero-extended
- ir_taken  in  1  CP0 accepted the interrupt (CP0 `ir` high)
- eret  in  1  ERET executed (CP0 oper equals ERET)
- ir_out  out  1  to CP0 interrupt input
- active_id  out  ID_W  index of the source in service
- busy  out  1  an interrupt is asserted or in service

## Operation
- Registers, all reset to 0:
  - MASK[N_SRC-1:0]: 1 enables the source.
  - MODE[N_SRC-1:0]: 1 selects edge mode, 0 selects level mode.
  - PENDING[N_SRC-1:0]
  - CAUSE = {busy at bit 31, active_id at bits ID_W-1:0}
- Edge mode: PENDING[i] sets when irq_src[i] is 1 and the previous sample was 0. The set is sticky.
- Level mode: PENDING[i] is set every cycle irq_src[i] is 1. It is not cleared when the input drops. Software clears it.
- Writing PENDING is write-1-to-clear. If a set and a W1C hit the same bit in the same cycle, the set wins.
- Writes to CAUSE are ignored.
- eligible = PENDING & MASK. The winner is the lowest set index.
- FSM states: IDLE, ASSERT, SERVICE, GAP.
  - IDLE → ASSERT when eligible is nonzero. active_id latches the winner. PENDING[winner] clears, unless a new set hits it in the same cycle.
  - ASSERT: ir_out = 1. → SERVICE on ir_taken.
  - SERVICE: ir_out = 0. → GAP on eret.
  - GAP: ir_out = 0 for exactly one cycle, so CP0 sees a fresh rising edge. → IDLE.
- Outputs by state:
  - busy = 1 in ASSERT and SERVICE.
  - active_id holds its value until the next IDLE→ASSERT transition.
- Once ASSERT is entered, the choice is committed. Masking or clearing the source while in ASSERT does not deassert ir_out.
- ir_taken outside ASSERT is ignored. eret outside SERVICE is ignored.
- rst in any state: all registers and outputs go to 0, FSM goes to IDLE, and the edge-detect history is cleared.

## Timing
- Reset values: ir_out 0, busy 0, active_id 0, cfg_rdata reflects MASK, which is 0.
- Source request to ir_out:
  - irq_src[i] rises with the sample at posedge k.
  - PENDING[i] = 1 after posedge k.
  - ASSERT and ir_out = 1 after posedge k+1, provided the FSM was IDLE and the source is masked in.
- A cfg write at posedge k takes effect for arbitration at posedge k+1.
- ir_taken sampled at posedge k: ir_out = 0 after posedge k.
- eret sampled at posedge k:
  - GAP after posedge k.
  - IDLE after posedge k+1.
  - The earliest next ir_out = 1 is after posedge k+2.
- Throughput: at most one interrupt per (ASSERT + SERVICE + 2) cycles.

## Structure
- Package irq_sched_pkg holds:
  - cfg address constants: CFG_MASK = 0, CFG_PEND = 1, CFG_CAUSE = 2, CFG_MODE = 3
  - the FSM state encoding: IDLE = 0, ASSERT = 1, SERVICE = 2, GAP = 3
  - the lowest-index priority-encoder function
- One sub-module, irq_pending_cell. It is instantiated N_SRC times and holds:
  - the previous-sample flop
  - edge/level set logic
  - the W1C and grant-clear logic
  - the PENDING bit
- The top level holds the cfg registers, the arbiter and the FSM.

## Test plan
- Reset, then edge-mode source 3 pulses high for one cycle with MASK = 0x08:
  - PENDING = 0x08 after that posedge.
  - ir_out = 1 one cycle later, active_id = 3.
  - PENDING = 0x00 after entry to ASSERT.
- Sources 5 and 2 rise in the same cycle with MASK = 0xFF:
  - active_id = 2 first.
  - After ir_taken and eret, ir_out rises again two cycles after eret with active_id = 5.
- Source 1 pulses while MASK = 0:
  - PENDING[1] = 1, ir_out stays 0.
  - Writing MASK = 0x02 raises ir_out the cycle after the write takes effect.
- Level-mode source 0 held high through its handler and eret:
  - ir_out drops in GAP for exactly one cycle, then re-asserts with active_id = 0.
  - The bench checks that CP0 sees two distinct rising edges.
- W1C on PENDING[4] in the same cycle as a new edge on source 4:
  - PENDING[4] stays 1.
- rst asserted during SERVICE:
  - The next cycle shows ir_out = 0, busy = 0, PENDING = 0, MASK = 0.
  - A subsequent eret is ignored.
